mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DSIZE, default `DSIZE, data width.
REQ-002 SHALL have parameter ASIZE, default `ASIZE, register-address width.
REQ-003 SHALL have parameter ISIZE, default `ISIZE, PC width.
REQ-004 SHALL have parameter TMO, default 255, dmem ack timeout in cycles (8-bit).
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 aluout_in  in  DSIZE  EXE/MEM ALU result; memory byte address for loads/stores.
REQ-008 rdata2_in  in  DSIZE  store data.
REQ-009 waddr_in  in  ASIZE  destination register.
REQ-010 wen_in, memread_in, memwrite_in, memtoreg_in, jal_in  in  1 each  EXE/MEM control.
REQ-011 PCOUT_in  in  ISIZE  return address used by jal.
REQ-012 stall  out  1  combinational; high freezes PC, IF/ID, ID/EXE and EXE/MEM.
REQ-013 dmem_req  out  1  memory request, registered.
REQ-014 dmem_we  out  1  1 = write, 0 = read, registered.
REQ-015 dmem_addr  out  DSIZE  registered.
REQ-016 dmem_wdata  out  DSIZE  registered.
REQ-017 dmem_rdata  in  DSIZE  read data, valid when dmem_ack is high.
REQ-018 dmem_ack  in  1  single-cycle completion pulse.
REQ-019 wb_data, wb_waddr, wb_wen  out  DSIZE/ASIZE/1  MEM/WB register to writeback.
REQ-020 err  out  1  sticky error flag.

Function
REQ-021 SHALL implement FSM states IDLE and BUSY.
REQ-022 memop SHALL be defined as memread_in | memwrite_in; illegal SHALL be defined as memread_in & memwrite_in.
REQ-023 IDLE with memop & !illegal SHALL assert stall, and at the edge SHALL load dmem_addr=aluout_in, dmem_wdata=rdata2_in, dmem_we=memwrite_in, dmem_req=1, and go to BUSY.
REQ-024 BUSY SHALL assert stall = !dmem_ack.
REQ-025 BUSY with dmem_ack SHALL clear dmem_req and return to IDLE at the edge.
REQ-026 dmem_ack SHALL be ignored in IDLE.
REQ-027 Minimum memory-op latency SHALL be 2 cycles (the IDLE cycle plus the ack cycle).
REQ-028 BUSY SHALL count cycles; if the count reaches TMO without dmem_ack, the unit SHALL set err, clear dmem_req, insert a bubble, and return to IDLE, with stall low in that cycle.
REQ-029 illegal in IDLE SHALL set err, issue no request, and insert a bubble, with stall low.
REQ-030 At each edge where stall is low, the MEM/WB register SHALL load:
  - wb_waddr = waddr_in
  - wb_wen = wen_in & (waddr_in != 0), or 0 on bubble
  - wb_data = PCOUT_in if jal_in; else dmem_rdata if memtoreg_in; else aluout_in
  - jal_in SHALL have priority over memtoreg_in.
REQ-031 At each edge where stall is high, the unit SHALL load a bubble (wb_wen=0; wb_data and wb_waddr held).
REQ-032 A non-memop instruction SHALL pass with stall low and 1-cycle latency to wb_*.
REQ-033 A store SHALL complete with wb_wen = wen_in (normally 0).
REQ-034 err SHALL be cleared only by reset.

Reset
REQ-035 rst_n low SHALL immediately force: state=IDLE, dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, wb_data=0, wb_waddr=0, wb_wen=0, err=0, timeout counter=0.
REQ-036 stall SHALL be 0 while rst_n is low.
REQ-037 Reset in BUSY SHALL abandon the access; a late dmem_ack after release SHALL be ignored.
REQ-038 After rst_n rises, the first edge SHALL process inputs normally.

Verification
REQ-039 R-type aluout_in=0x1234, waddr_in=5, wen_in=1 -> stall=0; next edge wb_data=0x1234, wb_waddr=5, wb_wen=1.
REQ-040 Load aluout_in=0x40, memtoreg_in=1, waddr_in=3; ack 3 cycles after req with rdata=0xDEADBEEF -> dmem_addr=0x40, dmem_we=0; stall high 4 cycles; then wb_data=0xDEADBEEF, wb_wen=1, with bubbles before.
REQ-041 Store aluout_in=0x80, rdata2_in=0xCAFE, ack on first BUSY cycle -> dmem_we=1, dmem_wdata=0xCAFE, stall high exactly 1 cycle, wb_wen=0.
REQ-042 Load with no ack -> dmem_req drops after 255 BUSY cycles; err=1, wb_wen=0; the following R-type passes normally.
REQ-043 jal_in=1, PCOUT_in=0x100, waddr_in=31 -> wb_data=0x100; memread_in=memwrite_in=1 -> err=1, no dmem_req; waddr_in=0, wen_in=1 -> wb_wen=0.
REQ-044 rst_n pulsed low during BUSY -> dmem_req=0 and stall=0 immediately; ack one cycle after release -> no wb_wen and no state change.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM stage of the pipeline: drives a request/ack data memory port, stalls the
// pipeline while an access is outstanding and feeds the MEM/WB register.
`ifndef DSIZE
`define DSIZE 32
`endif
`ifndef ASIZE
`define ASIZE 5
`endif
`ifndef ISIZE
`define ISIZE 32
`endif

module mem_access_unit #(
   parameter int         DSIZE = `DSIZE,
   parameter int         ASIZE = `ASIZE,
   parameter int         ISIZE = `ISIZE,
   parameter logic [7:0] TMO   = 8'd255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DSIZE-1:0] aluout_in,
   input  logic [DSIZE-1:0] rdata2_in,
   input  logic [ASIZE-1:0] waddr_in,
   input  logic             wen_in,
   input  logic             memread_in,
   input  logic             memwrite_in,
   input  logic             memtoreg_in,
   input  logic             jal_in,
   input  logic [ISIZE-1:0] PCOUT_in,
   output logic             stall,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic [DSIZE-1:0] dmem_addr,
   output logic [DSIZE-1:0] dmem_wdata,
   input  logic [DSIZE-1:0] dmem_rdata,
   input  logic             dmem_ack,
   output logic [DSIZE-1:0] wb_data,
   output logic [ASIZE-1:0] wb_waddr,
   output logic             wb_wen,
   output logic             err
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t           state;
   logic [7:0]       cnt;
   logic             memop;
   logic             illegal;
   logic             timeout;
   logic             bubble;
   logic [DSIZE-1:0] wb_next;

   assign memop   = memread_in | memwrite_in;
   assign illegal = memread_in & memwrite_in;
   // cnt holds the number of BUSY cycles already spent, so the TMO-th BUSY cycle aborts
   assign timeout = (state == BUSY) && !dmem_ack && (cnt == TMO - 8'd1);

   always_comb begin
      stall  = 1'b0;
      bubble = 1'b0;
      if (rst_n) begin
         case (state)
            IDLE: begin
               if (illegal)    bubble = 1'b1;
               else if (memop) stall  = 1'b1;
            end
            BUSY: begin
               if (timeout)        bubble = 1'b1;
               else if (!dmem_ack) stall  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      wb_next = aluout_in;
      if (jal_in)           wb_next = DSIZE'(PCOUT_in);
      else if (memtoreg_in) wb_next = dmem_rdata;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         wb_data    <= '0;
         wb_waddr   <= '0;
         wb_wen     <= 1'b0;
         err        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (illegal) begin
                  err <= 1'b1;
               end else if (memop) begin
                  dmem_req   <= 1'b1;
                  dmem_we    <= memwrite_in;
                  dmem_addr  <= aluout_in;
                  dmem_wdata <= rdata2_in;
                  cnt        <= '0;
                  state      <= BUSY;
               end
            end
            BUSY: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  state    <= IDLE;
               end else if (timeout) begin
                  dmem_req <= 1'b0;
                  err      <= 1'b1;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase

         if (stall) begin
            wb_wen <= 1'b0;
         end else begin
            wb_waddr <= waddr_in;
            wb_data  <= wb_next;
            wb_wen   <= !bubble && wen_in && (waddr_in != '0);
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level reference model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_access_unit;

   localparam int DW  = 32;
   localparam int AW  = 5;
   localparam int IW  = 32;
   localparam int TMO = 255;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [DW-1:0] aluout_in = '0, rdata2_in = '0, dmem_rdata = '0;
   logic [AW-1:0] waddr_in = '0;
   logic          wen_in = 0, memread_in = 0, memwrite_in = 0, memtoreg_in = 0, jal_in = 0;
   logic [IW-1:0] PCOUT_in = '0;
   logic          dmem_ack = 0;
   logic          stall, dmem_req, dmem_we, wb_wen, err;
   logic [DW-1:0] dmem_addr, dmem_wdata, wb_data;
   logic [AW-1:0] wb_waddr;

   int n_cmp = 0;
   int n_bad = 0;

   mem_access_unit #(.DSIZE(DW), .ASIZE(AW), .ISIZE(IW), .TMO(8'(TMO))) dut (
      .clk(clk), .rst_n(rst_n),
      .aluout_in(aluout_in), .rdata2_in(rdata2_in), .waddr_in(waddr_in),
      .wen_in(wen_in), .memread_in(memread_in), .memwrite_in(memwrite_in),
      .memtoreg_in(memtoreg_in), .jal_in(jal_in), .PCOUT_in(PCOUT_in),
      .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
      .wb_data(wb_data), .wb_waddr(wb_waddr), .wb_wen(wb_wen), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an access is outstanding from the cycle after it starts;
   // age = cycles since it started, so age==TMO is the last cycle it may wait.
   int            cyc, acc_start;
   logic          m_active, m_req, m_we, m_err, m_wb_wen;
   logic [DW-1:0] m_addr, m_wdata, m_wb_data;
   logic [AW-1:0] m_wb_waddr;

   function automatic logic f_stall();
      if (!rst_n) return 1'b0;
      if (!m_active) return memread_in ^ memwrite_in;
      return !dmem_ack && (cyc - acc_start != TMO);
   endfunction

   function automatic logic f_bubble();
      if (!m_active) return memread_in && memwrite_in;
      return !dmem_ack && (cyc - acc_start == TMO);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cyc <= 0; acc_start <= 0; m_active <= 0; m_req <= 0; m_we <= 0; m_err <= 0;
         m_addr <= '0; m_wdata <= '0; m_wb_data <= '0; m_wb_waddr <= '0; m_wb_wen <= 0;
      end else begin
         cyc <= cyc + 1;
         if (f_stall()) m_wb_wen <= 1'b0;
         else begin
            m_wb_waddr <= waddr_in;
            m_wb_data  <= jal_in ? DW'(PCOUT_in) : (memtoreg_in ? dmem_rdata : aluout_in);
            m_wb_wen   <= !f_bubble() && wen_in && waddr_in != 0;
         end
         if (!m_active) begin
            if (memread_in && memwrite_in) m_err <= 1'b1;
            else if (memread_in || memwrite_in) begin
               m_active <= 1'b1; acc_start <= cyc; m_req <= 1'b1;
               m_we <= memwrite_in; m_addr <= aluout_in; m_wdata <= rdata2_in;
            end
         end else if (dmem_ack) begin
            m_active <= 1'b0; m_req <= 1'b0;
         end else if (cyc - acc_start == TMO) begin
            m_active <= 1'b0; m_req <= 1'b0; m_err <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      check("stall", 32'(stall), 32'(f_stall()));
      check("dmem_req", 32'(dmem_req), 32'(m_req));
      check("dmem_we", 32'(dmem_we), 32'(m_we));
      check("dmem_addr", dmem_addr, m_addr);
      check("dmem_wdata", dmem_wdata, m_wdata);
      check("wb_data", wb_data, m_wb_data);
      check("wb_waddr", 32'(wb_waddr), 32'(m_wb_waddr));
      check("wb_wen", 32'(wb_wen), 32'(m_wb_wen));
      check("err", 32'(err), 32'(m_err));
   end

   task automatic nop();
      aluout_in = '0; rdata2_in = '0; waddr_in = '0; wen_in = 0; memread_in = 0;
      memwrite_in = 0; memtoreg_in = 0; jal_in = 0; PCOUT_in = '0; dmem_ack = 0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   // Holds the current instruction until stall drops; ack pulses in cycle ack_at
   // (cycle 0 is the issuing cycle), never if ack_at < 0.
   task automatic run_op(input int ack_at, input logic [DW-1:0] rd,
                         output int stalls, output int reqs,
                         output logic [DW-1:0] c_addr, output logic [DW-1:0] c_wdata,
                         output logic c_we);
      logic s;
      stalls = 0; reqs = 0; c_addr = '0; c_wdata = '0; c_we = 0;
      for (int k = 0; k < TMO + 20; k++) begin
         dmem_ack   = (k == ack_at);
         dmem_rdata = (k == ack_at) ? rd : 32'h0BAD_0BAD;
         #1;
         s = stall;
         if (s) stalls++;
         if (dmem_req) reqs++;
         if (k == 1) begin c_addr = dmem_addr; c_wdata = dmem_wdata; c_we = dmem_we; end
         step();
         if (!s) begin dmem_ack = 0; return; end
      end
      check("op_completes_within_bound", 32'(0), 32'(1));
      dmem_ack = 0;
   endtask

   int st, rq;
   logic [DW-1:0] ca, cw;
   logic cwe;

   initial begin
      nop();
      #3;
      check("rst_stall", 32'(stall), 0);
      check("rst_req", 32'(dmem_req), 0);
      check("rst_wb_wen", 32'(wb_wen), 0);
      check("rst_err", 32'(err), 0);
      #19 rst_n = 1'b1;
      step();

      // R-type, with a stray ack that must be ignored in IDLE
      aluout_in = 32'h1234; waddr_in = 5; wen_in = 1; dmem_ack = 1;
      #1 check("rtype_stall", 32'(stall), 0);
      step();
      check("rtype_wb_data", wb_data, 32'h1234);
      check("rtype_wb_waddr", 32'(wb_waddr), 5);
      check("rtype_wb_wen", 32'(wb_wen), 1);
      check("idle_ack_no_req", 32'(dmem_req), 0);
      nop();

      // load, ack three cycles after the request appears
      aluout_in = 32'h40; memread_in = 1; memtoreg_in = 1; waddr_in = 3; wen_in = 1;
      run_op(4, 32'hDEADBEEF, st, rq, ca, cw, cwe);
      check("load_addr", ca, 32'h40);
      check("load_we", 32'(cwe), 0);
      check("load_stall_cycles", st, 4);
      check("load_wb_data", wb_data, 32'hDEADBEEF);
      check("load_wb_wen", 32'(wb_wen), 1);
      check("load_req_dropped", 32'(dmem_req), 0);
      nop();

      // store, ack on the first busy cycle
      aluout_in = 32'h80; rdata2_in = 32'hCAFE; memwrite_in = 1; waddr_in = 7; wen_in = 0;
      run_op(1, 32'h0, st, rq, ca, cw, cwe);
      check("store_we", 32'(cwe), 1);
      check("store_wdata", cw, 32'hCAFE);
      check("store_addr", ca, 32'h80);
      check("store_stall_cycles", st, 1);
      check("store_wb_wen", 32'(wb_wen), 0);
      nop();

      // load never acknowledged
      aluout_in = 32'h44; memread_in = 1; memtoreg_in = 1; waddr_in = 9; wen_in = 1;
      run_op(-1, 32'h0, st, rq, ca, cw, cwe);
      check("tmo_req_cycles", rq, 255);
      check("tmo_err", 32'(err), 1);
      check("tmo_wb_wen", 32'(wb_wen), 0);
      check("tmo_req_dropped", 32'(dmem_req), 0);
      nop();
      aluout_in = 32'h55; waddr_in = 6; wen_in = 1;
      #1 check("post_tmo_stall", 32'(stall), 0);
      step();
      check("post_tmo_wb_data", wb_data, 32'h55);
      check("post_tmo_wb_wen", 32'(wb_wen), 1);
      nop();

      // reset clears the sticky error
      rst_n = 0; #1 check("err_cleared", 32'(err), 0);
      step(); rst_n = 1; step();

      jal_in = 1; memtoreg_in = 1; PCOUT_in = 32'h100; aluout_in = 32'h999; waddr_in = 31; wen_in = 1;
      step();
      check("jal_wb_data", wb_data, 32'h100);
      check("jal_wb_wen", 32'(wb_wen), 1);
      nop();
      memread_in = 1; memwrite_in = 1; waddr_in = 4; wen_in = 1;
      #1 check("illegal_stall", 32'(stall), 0);
      step();
      check("illegal_err", 32'(err), 1);
      check("illegal_no_req", 32'(dmem_req), 0);
      check("illegal_wb_wen", 32'(wb_wen), 0);
      nop();
      aluout_in = 32'h77; waddr_in = 0; wen_in = 1;
      step();
      check("r0_wb_wen", 32'(wb_wen), 0);
      check("r0_wb_data", wb_data, 32'h77);
      nop();

      // reset while an access is outstanding, then a late ack
      aluout_in = 32'h60; memread_in = 1; memtoreg_in = 1; waddr_in = 2; wen_in = 1;
      step();
      check("busy_req", 32'(dmem_req), 1);
      rst_n = 0;
      #1 check("rst_busy_req", 32'(dmem_req), 0);
      check("rst_busy_stall", 32'(stall), 0);
      nop();
      step(); rst_n = 1;
      step();
      dmem_ack = 1; dmem_rdata = 32'hBAD;
      #1 check("late_ack_stall", 32'(stall), 0);
      step();
      check("late_ack_wb_wen", 32'(wb_wen), 0);
      check("late_ack_req", 32'(dmem_req), 0);
      nop();
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1);
   end

endmodule
